// File: rtl/qam16_symbol_decimator.sv
// Per-symbol decimator with energy-based symbol-timing acquisition for 16-QAM RX.
// Optional Gray slicer on the decimated sample: define QAM16_DS_SLICER_EN.
module qam16_symbol_decimator #(
  parameter int SPS       = 11,
  parameter int DW        = 12,
  parameter int ACQ_SYMS  = 16,
  parameter int SLICE_THR = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] i_in,
  input  logic [DW-1:0] q_in,
  input  logic          resync,
  output logic [DW-1:0] i_sym,
  output logic [DW-1:0] q_sym,
  output logic          sym_valid,
  output logic          locked,
  output logic [3:0]    phase_sel,
  output logic [3:0]    sym_out
);

  localparam int ACC_W = DW + 1 + $clog2(ACQ_SYMS);
  localparam int TOTAL = ACQ_SYMS * SPS;
  localparam int CW    = $clog2(TOTAL);

  localparam logic [1:0] ST_ACQ = 2'd0;
  localparam logic [1:0] ST_DEC = 2'd1;
  localparam logic [1:0] ST_TRK = 2'd2;

  localparam logic [3:0]    PH_LAST  = 4'(SPS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TOTAL - 1);
  localparam logic signed [DW:0] THR = (DW + 1)'(SLICE_THR);

  function automatic logic [DW:0] mag(input logic [DW-1:0] x);
    mag = x[DW-1] ? (~{x[DW-1], x} + 1'b1) : {1'b0, x};
  endfunction

  logic [1:0]       state_q, state_d;
  logic [3:0]       phase_q;
  logic [CW-1:0]    cnt_q;
  logic [ACC_W-1:0] acc_q [SPS];
  logic [3:0]       scan_q;
  logic [3:0]       best_q;
  logic [ACC_W-1:0] best_val_q;
  logic [3:0]       phase_sel_q;
  logic [DW-1:0]    i_sym_q, q_sym_q;
  logic             sym_valid_q;

  logic [DW:0] mag_sum;
  logic        hit;
  logic        better;
  logic        acq_last;

  assign mag_sum  = mag(i_in) + mag(q_in);
  assign better   = acc_q[scan_q] > best_val_q;
  assign acq_last = in_valid && (cnt_q == CNT_LAST);
  assign hit      = (state_q == ST_TRK) && in_valid && !resync &&
                    (phase_q == phase_sel_q);

  always_comb begin
    state_d = state_q;
    if (resync) begin
      state_d = ST_ACQ;
    end else begin
      case (state_q)
        ST_ACQ:  if (acq_last) state_d = ST_DEC;
        ST_DEC:  if (scan_q == PH_LAST) state_d = ST_TRK;
        ST_TRK:  state_d = ST_TRK;
        default: state_d = ST_ACQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_ACQ;
      phase_q     <= '0;
      cnt_q       <= '0;
      scan_q      <= '0;
      best_q      <= '0;
      best_val_q  <= '0;
      phase_sel_q <= '0;
      i_sym_q     <= '0;
      q_sym_q     <= '0;
      sym_valid_q <= 1'b0;
      for (int k = 0; k < SPS; k++) acc_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      sym_valid_q <= hit;
      if (in_valid)
        phase_q <= (phase_q == PH_LAST) ? 4'd0 : phase_q + 4'd1;
      if (resync) begin
        cnt_q <= '0;
        for (int k = 0; k < SPS; k++) acc_q[k] <= '0;
      end else begin
        case (state_q)
          ST_ACQ: begin
            if (in_valid) begin
              acc_q[phase_q] <= acc_q[phase_q] + ACC_W'(mag_sum);
              cnt_q          <= acq_last ? '0 : cnt_q + 1'b1;
            end
            if (acq_last) begin
              scan_q     <= '0;
              best_q     <= '0;
              best_val_q <= '0;
            end
          end
          ST_DEC: begin
            scan_q <= scan_q + 4'd1;
            // strict compare keeps the lowest index on ties
            if (better) begin
              best_q     <= scan_q;
              best_val_q <= acc_q[scan_q];
            end
            if (scan_q == PH_LAST)
              phase_sel_q <= better ? scan_q : best_q;
          end
          default: ;
        endcase
      end
      if (hit) begin
        i_sym_q <= i_in;
        q_sym_q <= q_in;
      end
    end
  end

  assign i_sym     = i_sym_q;
  assign q_sym     = q_sym_q;
  assign sym_valid = sym_valid_q;
  assign locked    = (state_q == ST_TRK);
  assign phase_sel = phase_sel_q;

`ifdef QAM16_DS_SLICER_EN
  function automatic logic [1:0] slice(input logic [DW-1:0] x);
    logic signed [DW:0] v;
    v = $signed({x[DW-1], x});
    if (v < -THR)     slice = 2'b00;
    else if (v[DW])   slice = 2'b01;
    else if (v < THR) slice = 2'b11;
    else              slice = 2'b10;
  endfunction

  logic [3:0] sym_q;

  always_ff @(posedge clk) begin
    if (reset)    sym_q <= '0;
    else if (hit) sym_q <= {slice(i_in), slice(q_in)};
  end

  assign sym_out = sym_q;
`else
  logic unused_thr;
  assign unused_thr = ^THR;
  assign sym_out    = 4'd0;
`endif

endmodule

// File: tb/tb_qam16_symbol_decimator.sv
// Directed bench for qam16_symbol_decimator: acquisition, tracking, resync, reset.
// Slicer vectors checked against Gray codes when QAM16_DS_SLICER_EN is defined.
module tb_qam16_symbol_decimator;
  localparam int SPS   = 11;
  localparam int DW    = 12;
  localparam int TOTAL = 16 * SPS;

`ifdef QAM16_DS_SLICER_EN
  localparam bit SLC = 1'b1;
`else
  localparam bit SLC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, in_valid, resync;
  logic [DW-1:0] i_in, q_in, i_sym, q_sym;
  logic          sym_valid, locked;
  logic [3:0]    phase_sel, sym_out;

  always #5 clk = ~clk;

  qam16_symbol_decimator #(
    .SPS(SPS), .DW(DW), .ACQ_SYMS(16), .SLICE_THR(1024)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .i_in(i_in), .q_in(q_in), .resync(resync),
    .i_sym(i_sym), .q_sym(q_sym), .sym_valid(sym_valid),
    .locked(locked), .phase_sel(phase_sel), .sym_out(sym_out)
  );

  typedef struct {
    logic signed [DW-1:0] i;
    logic signed [DW-1:0] q;
    logic [3:0]           slc;
  } vec_t;

  vec_t tbl [8];
  int   tests = 0;
  int   fails = 0;
  int   ph    = 0;

  task automatic chk(input string name, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step(input logic rst, input logic v, input logic rs,
                      input logic [DW-1:0] i, input logic [DW-1:0] q);
    reset = rst; in_valid = v; resync = rs; i_in = i; q_in = q;
    @(posedge clk);
    @(negedge clk);
    if (rst)    ph = 0;
    else if (v) ph = (ph == SPS - 1) ? 0 : ph + 1;
  endtask

  task automatic samp(input int p, input logic v,
                      input logic signed [DW-1:0] i,
                      input logic signed [DW-1:0] q, output logic h);
    h = v && (ph == p);
    step(1'b0, v, 1'b0, h ? i : '0, h ? q : '0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_i_sym"}, $signed(i_sym), 0);
    chk({tag, "_q_sym"}, $signed(q_sym), 0);
    chk({tag, "_sym_valid"}, sym_valid, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_phase_sel"}, phase_sel, 0);
    chk({tag, "_sym_out"}, sym_out, 0);
  endtask

  // From a fresh ACQUIRE: TOTAL valid samples, then SPS DECIDE cycles.
  task automatic acquire(input string tag, input int p, input bit tog,
                         input logic signed [DW-1:0] i,
                         input logic signed [DW-1:0] q, input int exp_p);
    int   nval = 0;
    int   bad  = 0;
    int   k    = 0;
    logic v, h;
    while (nval < TOTAL) begin
      v = tog ? (k % 2 == 0) : 1'b1;
      samp(p, v, i, q, h);
      if (v) nval++;
      k++;
      if (locked || sym_valid) bad++;
    end
    for (int d = 0; d < SPS; d++) begin
      v = tog ? (k % 2 == 0) : 1'b1;
      samp(p, v, i, q, h);
      k++;
      if (d < SPS - 1 && (locked || sym_valid)) bad++;
    end
    chk({tag, "_early_lock_or_strobe"}, bad, 0);
    chk({tag, "_locked"}, locked, 1);
    chk({tag, "_phase_sel"}, phase_sel, exp_p);
    chk({tag, "_no_strobe_at_lock"}, sym_valid, 0);
  endtask

  task automatic track(input string tag, input int p, input bit tog,
                       input logic signed [DW-1:0] i,
                       input logic signed [DW-1:0] q,
                       input int n, input int exp_strobes);
    int   strobes = 0;
    logic v, h;
    for (int k = 0; k < n; k++) begin
      v = tog ? (k % 2 == 0) : 1'b1;
      samp(p, v, i, q, h);
      chk({tag, "_sym_valid"}, sym_valid, h);
      if (sym_valid) strobes++;
      if (h) begin
        chk({tag, "_i_sym"}, $signed(i_sym), i);
        chk({tag, "_q_sym"}, $signed(q_sym), q);
      end
    end
    chk({tag, "_strobe_count"}, strobes, exp_strobes);
  endtask

  initial begin
    logic h;
    logic signed [DW-1:0] last_i;

    tbl[0] = '{i: 12'sd300,   q: -12'sd500,  slc: 4'b1101};
    tbl[1] = '{i: 12'sd1500,  q: -12'sd200,  slc: 4'b1001};
    tbl[2] = '{i: -12'sd1024, q: 12'sd1023,  slc: 4'b0111};
    tbl[3] = '{i: -12'sd2048, q: 12'sd0,     slc: 4'b0011};
    tbl[4] = '{i: 12'sd2047,  q: -12'sd2048, slc: 4'b1000};
    tbl[5] = '{i: -12'sd1025, q: 12'sd1024,  slc: 4'b0010};
    tbl[6] = '{i: 12'sd0,     q: -12'sd1,    slc: 4'b1101};
    tbl[7] = '{i: 12'sd1024,  q: -12'sd1024, slc: 4'b1001};

    reset = 1'b1; in_valid = 1'b0; resync = 1'b0; i_in = '0; q_in = '0;
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    check_reset_vals("por");

    acquire("ph3", 3, 1'b0, 12'sd300, -12'sd500, 3);
    track("ph3", 3, 1'b0, 12'sd300, -12'sd500, 44, 4);

    for (int n = 0; n < 8; n++) begin
      while (ph != 3) samp(3, 1'b1, '0, '0, h);
      step(1'b0, 1'b1, 1'b0, tbl[n].i, tbl[n].q);
      chk("vec_sym_valid", sym_valid, 1);
      chk("vec_i_sym", $signed(i_sym), tbl[n].i);
      chk("vec_q_sym", $signed(q_sym), tbl[n].q);
      chk("vec_sym_out", sym_out, SLC ? tbl[n].slc : 4'd0);
      step(1'b0, 1'b1, 1'b0, '0, '0);
      chk("vec_hold_valid", sym_valid, 0);
      chk("vec_hold_i", $signed(i_sym), tbl[n].i);
    end
    last_i = tbl[7].i;

    while (ph != 3) samp(3, 1'b1, '0, '0, h);
    step(1'b0, 1'b1, 1'b1, 12'd777, 12'd5);
    chk("resync_locked", locked, 0);
    chk("resync_no_strobe", sym_valid, 0);
    chk("resync_phase_hold", phase_sel, 3);
    chk("resync_i_hold", $signed(i_sym), last_i);
    acquire("ph8", 8, 1'b0, 12'sd300, -12'sd500, 8);
    track("ph8", 8, 1'b0, 12'sd300, -12'sd500, 22, 2);

    step(1'b1, 1'b1, 1'b0, 12'd100, 12'd100);
    check_reset_vals("rst_trk");

    for (int k = 0; k < 50; k++) samp(5, 1'b1, 12'sd1000, 12'sd1000, h);
    step(1'b1, 1'b1, 1'b0, 12'd1000, 12'd1000);
    check_reset_vals("rst_acq");
    acquire("zero", 0, 1'b0, '0, '0, 0);

    step(1'b1, 1'b0, 1'b0, '0, '0);
    check_reset_vals("rst_tog");
    acquire("tog7", 7, 1'b1, 12'sd300, -12'sd500, 7);
    track("tog7", 7, 1'b1, 12'sd300, -12'sd500, 66, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/qam16_symbol_decimator.md
# qam16_symbol_decimator

Receive-side counterpart of the TX zero-stuffing upsampler: accepts the SPS-samples-per-symbol I/Q stream (post matched filter or direct loopback of the upsampler output) and emits one I/Q sample per symbol. It contains a symbol-timing acquisition FSM that measures energy per sample phase over a fixed window, then locks to the strongest phase and decimates. It sits between the RX filter and the 16-QAM demapper.

## Interface
- SPS, 11, samples per symbol (2..16); phase counter runs 0..SPS-1
- DW, 12, signed I/Q sample width
- ACQ_SYMS, 16, symbols per acquisition window (power of 2, ≥2)
- SLICE_THR, 1024, positive inner/outer decision threshold (slicer only)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  i_in/q_in carry a sample this cycle
- i_in  in  DW  signed I sample
- q_in  in  DW  signed Q sample
- resync  in  1  single-cycle request to restart acquisition
- i_sym  out  DW  decimated I sample, held between strobes
- q_sym  out  DW  decimated Q sample, held between strobes
- sym_valid  out  1  one-cycle strobe, i_sym/q_sym (and sym_out) updated
- locked  out  1  high while in TRACK
- phase_sel  out  4  selected sample phase (valid when locked)
- sym_out  out  4  sliced symbol {I bits, Q bits}; 0 when slicer compiled out

## Operation
- phase_cnt: advances by 1 on each in_valid, wraps SPS-1 -> 0; never stalls in any state; untouched when in_valid=0.
- FSM states ACQUIRE, DECIDE, TRACK.
- ACQUIRE: on each in_valid, acc[phase_cnt] += |i_in| + |q_in| (magnitude term DW+1 bits unsigned; |−2^(DW−1)| = 2^(DW−1) exactly, no saturation). Accumulators are ACC_W = DW+1+log2(ACQ_SYMS) bits; cannot overflow. After ACQ_SYMS*SPS valid samples -> DECIDE.
- ACQUIRE is entered with all accumulators and the sample counter cleared; phase_cnt is not cleared.
- DECIDE: scans acc[0..SPS-1] one per cycle (SPS cycles, independent of in_valid); best replaced only on strictly greater, so ties resolve to lowest index. On completion phase_sel <= best, -> TRACK. Samples arriving during DECIDE are counted by phase_cnt but neither accumulated nor emitted.
- TRACK: when in_valid and phase_cnt == phase_sel, register i_in/q_in into i_sym/q_sym and pulse sym_valid.
- resync (any state): next state ACQUIRE, locked drops the following cycle, accumulators cleared; the sample (if any) on the resync cycle is not accumulated or emitted. phase_sel and i_sym/q_sym hold.
- reset priority over resync.

## Timing
- Reset values: i_sym=0, q_sym=0, sym_valid=0, locked=0, phase_sel=0, sym_out=0; state ACQUIRE, phase_cnt=0, accumulators 0.
- Decimation latency 1 cycle: sample at edge n -> sym_valid/i_sym/q_sym at edge n+1.
- With continuous in_valid from reset release: last acquisition sample accepted at cycle ACQ_SYMS*SPS−1, DECIDE occupies next SPS cycles, locked=1 and phase_sel valid the cycle after; first sym_valid follows the next occurrence of the selected phase.
- sym_valid never asserts outside TRACK; max one strobe per SPS valid samples.

## Configuration
- QAM16_DS_SLICER_EN defined: sym_out registered alongside i_sym/q_sym, per axis Gray code: x < −SLICE_THR -> 00, −SLICE_THR ≤ x < 0 -> 01, 0 ≤ x < SLICE_THR -> 11, x ≥ SLICE_THR -> 10; sym_out = {I bits, Q bits}.
- Undefined: slicer logic absent, sym_out tied 4'd0.

## Test plan
- Defaults, continuous in_valid, impulses only at phase 3 (I=300, Q=−500, others 0) -> locked at cycle 176+11+1, phase_sel=3, sym_valid every 11 samples carrying I=300, Q=−500.
- All-zero input for full window -> tie, phase_sel=0, locked=1.
- in_valid toggling 1/0 every cycle with impulses at phase 7 -> phase_sel=7; window spans 352 cycles; strobes every 22 cycles.
- Locked on phase 3, shift impulses to phase 8, pulse resync -> locked=0 next cycle, no sym_valid during reacquire, relock with phase_sel=8.
- reset asserted mid-ACQUIRE and mid-TRACK -> all outputs at reset values next cycle, full acquisition repeats.
- Slicer build, DW=12: I=1500,Q=−200 -> sym_out=4'b1001; I=−1024,Q=1023 -> 4'b0111; I=−2048,Q=0 -> 4'b0011.
